decimal_parser: RTL
===================

DECIMAL_PARSER -- requirements
Module: decimal_parser

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: in_data  input  8  ASCII character.
REQ-005 Port: in_valid  input  1  in_data present.
REQ-006 Port: in_ready  output  1  character accepted when in_valid and in_ready are both high on a clk edge.
REQ-007 Port: out_data  output  11  signed two's-complement parsed value, range -999..999.
REQ-008 Port: out_valid  output  1  result present.
REQ-009 Port: out_ready  input  1  result consumed when out_valid and out_ready are both high on a clk edge.
REQ-010 Port: out_sat  output  1  magnitude exceeded 999 and was clamped.
REQ-011 Port: out_err  output  1  token was malformed.

Function
REQ-012 Character classes SHALL be: digit 0x30-0x39; sign 0x2D ('-'); terminator 0x0A, 0x0D or 0x20; everything else is invalid.
REQ-013 The FSM SHALL have states IDLE, SIGN, DIGITS, DISCARD and OUT.
REQ-014 IDLE transitions: terminator -> stays in IDLE (ignored); digit -> DIGITS, magnitude = digit; sign -> SIGN, neg = 1; invalid -> DISCARD.
REQ-015 SIGN transitions: digit -> DIGITS; terminator -> OUT with err = 1; sign or invalid -> DISCARD.
REQ-016 DIGITS transitions: digit -> magnitude updated, stays in DIGITS; terminator -> OUT; sign or invalid -> DISCARD.
REQ-017 DISCARD SHALL drop characters until a terminator, then go to OUT with err = 1.
REQ-018 Magnitude update: the 10-bit magnitude SHALL become magnitude*10 + digit; if that exceeds 999, magnitude = 999 and sat = 1 (sticky for the token).
REQ-019 Arbitrary digit count SHALL be accepted; leading zeros are legal.
REQ-020 In OUT, out_data SHALL be -magnitude when neg = 1, otherwise +magnitude; "-0" yields 0.
REQ-021 In OUT, out_data SHALL be 0 when err = 1, with out_sat = 0.
REQ-022 One character SHALL be accepted per cycle; in_ready = 1 in every state except OUT.
REQ-023 Latency: the terminator is accepted on edge N, and out_valid, out_data, out_sat and out_err SHALL be registered and valid after edge N (one cycle).
REQ-024 The outputs SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-025 On an out handshake, the FSM SHALL return to IDLE with magnitude, neg, sat and err cleared, and in_ready = 1 on the following cycle.
REQ-026 out_sat and out_err SHALL be 0 whenever out_valid = 0.

Reset
REQ-027 Asserting rst SHALL, asynchronously, force IDLE, out_valid = 0, out_data = 0, out_sat = 0, out_err = 0 and in_ready = 1, and clear magnitude, neg, sat and err.
REQ-028 Reset mid-token or during OUT SHALL discard the partial or pending result without emitting it.

Configuration
REQ-029 Macro PARSER_NEG_EN defined: the sign character is handled per REQ-014/015/016 and negative results are produced.
REQ-030 Macro PARSER_NEG_EN undefined: the sign character is classed as invalid, the SIGN state and neg register are absent, and out_data is never negative.

Verification
REQ-031 Send "123\n" with out_ready=1 -> one out_valid pulse, out_data=123, sat=0, err=0, pulse one cycle after '\n' is accepted.
REQ-032 Send "-45 " (PARSER_NEG_EN defined) -> out_data=-45. Without the macro -> out_data=0, err=1.
REQ-033 Send "12345\n" -> out_data=999, sat=1. Send "-2000\n" -> out_data=-999, sat=1.
REQ-034 Send "1a2\n", then "-\n", then "  \n7\n" -> results in order: 0/err=1, 0/err=1, 7/err=0 (leading terminators ignored).
REQ-035 Send "5\n" with out_ready=0 for 4 cycles, then "6\n" queued -> in_ready=0 and out_data=5 held for 4 cycles; after the handshake, 6 is emitted next with no lost character.
REQ-036 Assert rst after "98" has been accepted, release it, then send "3\n" -> only out_data=3 is emitted.

Source files
------------

// File: rtl/decimal_parser.sv
// ASCII decimal token parser: digits with optional leading '-', clamped to +/-999.
// Define PARSER_NEG_EN to accept the sign character and produce negative results.
module decimal_parser (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sat,
  output logic        out_err
);

`ifdef PARSER_NEG_EN
  typedef enum logic [2:0] {StIdle, StSign, StDigits, StDiscard, StOut} state_e;
`else
  typedef enum logic [2:0] {StIdle, StDigits, StDiscard, StOut} state_e;
`endif

  state_e      state_q, state_d;
  logic [9:0]  mag_q, mag_d;
  logic        sat_q, sat_d;
  logic        err_q, err_d;
  logic [10:0] out_data_q, out_data_d;
  logic        out_sat_q, out_sat_d;
  logic        out_err_q, out_err_d;

  logic        accept, is_digit, is_term, neg, load_out, tok_err;
  logic [13:0] prod;
  logic [9:0]  mag_upd;
  logic        sat_hit;

  assign accept   = in_valid && in_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_term  = (in_data == 8'h0A) || (in_data == 8'h0D) || (in_data == 8'h20);

  // 999*10+9 fits in 14 bits; clamping makes sat sticky because 999 re-overflows.
  assign prod    = 14'(mag_q) * 14'd10 + 14'(in_data[3:0]);
  assign sat_hit = prod > 14'd999;
  assign mag_upd = sat_hit ? 10'd999 : prod[9:0];

`ifdef PARSER_NEG_EN
  logic is_sign, neg_q, neg_d;
  assign is_sign = (in_data == 8'h2D);
  assign neg     = neg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
  end
`else
  assign neg = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    sat_d      = sat_q;
    err_d      = err_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    out_err_d  = out_err_q;
    load_out   = 1'b0;
    tok_err    = err_q;
`ifdef PARSER_NEG_EN
    neg_d      = neg_q;
`endif
    unique case (state_q)
      StIdle: if (accept) begin
        if (is_digit) begin
          mag_d   = mag_upd;
          sat_d   = sat_hit;
          state_d = StDigits;
`ifdef PARSER_NEG_EN
        end else if (is_sign) begin
          neg_d   = 1'b1;
          state_d = StSign;
`endif
        end else if (!is_term) begin
          state_d = StDiscard;
        end
      end
`ifdef PARSER_NEG_EN
      StSign: if (accept) begin
        if (is_digit) begin
          mag_d   = mag_upd;
          sat_d   = sat_hit;
          state_d = StDigits;
        end else if (is_term) begin
          tok_err  = 1'b1;
          load_out = 1'b1;
        end else begin
          state_d = StDiscard;
        end
      end
`endif
      StDigits: if (accept) begin
        if (is_digit) begin
          mag_d = mag_upd;
          sat_d = sat_q | sat_hit;
        end else if (is_term) begin
          load_out = 1'b1;
        end else begin
          state_d = StDiscard;
        end
      end
      StDiscard: if (accept && is_term) begin
        tok_err  = 1'b1;
        load_out = 1'b1;
      end
      StOut: if (out_ready) begin
        state_d    = StIdle;
        mag_d      = '0;
        sat_d      = 1'b0;
        err_d      = 1'b0;
        out_data_d = '0;
        out_sat_d  = 1'b0;
        out_err_d  = 1'b0;
`ifdef PARSER_NEG_EN
        neg_d      = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase

    if (load_out) begin
      state_d   = StOut;
      err_d     = tok_err;
      out_err_d = tok_err;
      out_sat_d = !tok_err && sat_q;
      if (tok_err)  out_data_d = '0;
      else if (neg) out_data_d = 11'd0 - {1'b0, mag_q};
      else          out_data_d = {1'b0, mag_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mag_q      <= '0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      sat_q      <= sat_d;
      err_q      <= err_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      out_err_q  <= out_err_d;
    end
  end

  assign in_ready  = (state_q != StOut);
  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_err   = out_err_q;

endmodule
